modport_slave: RTL and testbench
================================

MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 SHALL have exactly one clock; reset SHALL be synchronous and active-high; ports SHALL be named HCLK and HRESETn.
REQ-002 HCLK  input  1  bus clock; all state updates on rising edge.
REQ-003 HRESETn  input  1  synchronous active-high reset (asserted = 1).
REQ-004 HSEL  input  1  slave select.
REQ-005 HADDR  input  8  byte address.
REQ-006 HWDATA  input  32  write data, driven in data phase.
REQ-007 HWRITE  input  1  1 = write, 0 = read.
REQ-008 HSIZE  input  3  0 = byte, 1 = halfword, 2 = word; 3..7 unsupported.
REQ-009 HBURST  input  3  burst type; accepted, no functional effect.
REQ-010 HPROT  input  4  protection; accepted, no functional effect.
REQ-011 HTRANS  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-012 HREADY  input  1  bus ready; address phase sampled only when 1.
REQ-013 HRDATA  output  32  read data.
REQ-014 HREADYOUT  output  1  slave ready.
REQ-015 HRESP  output  1  0 OKAY, 1 ERROR.

Function
REQ-016 Storage SHALL be 64 x 32-bit words (256 bytes), little-endian; word index HADDR[7:2], lane n = bits 8n+7:8n.
REQ-017 Transfer accepted when HSEL=1, HREADY=1, HTRANS[1]=1 at a rising edge; HADDR, HWRITE, HSIZE SHALL be registered then.
REQ-018 IDLE, BUSY, HSEL=0 or HREADY=0 SHALL start no transfer and leave memory unchanged; next data phase is zero-wait OKAY.
REQ-019 Legal transfers SHALL complete with zero wait states: HREADYOUT=1, HRESP=0 in the data phase.
REQ-020 Write: in the data-phase cycle, HWDATA lanes selected by registered HSIZE/HADDR[1:0] SHALL be written at that cycle's end; other lanes unchanged (byte: lane HADDR[1:0]; halfword: lanes HADDR[1]*2 and +1; word: all).
REQ-021 Read: HRDATA SHALL present the full addressed word during the data phase regardless of HSIZE; otherwise HRDATA holds its last value.
REQ-022 Back-to-back write then read to same word SHALL return the newly written data (no hazard).
REQ-023 SEQ transfers SHALL be treated identically to NONSEQ; address taken from HADDR, no internal incrementing.
REQ-024 Illegal transfer = HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.

Reset
REQ-025 While HRESETn=1 at a rising edge: HREADYOUT=1, HRESP=0, HRDATA=0, pending data phase cancelled, all memory words cleared to 0.
REQ-026 A transfer whose address phase coincides with reset SHALL be discarded; reset during an ERROR response SHALL abort it (HREADYOUT=1, HRESP=0 next cycle).

Configuration
REQ-027 Macro AHB_ERR_RESP_EN defined: illegal transfer SHALL give a two-cycle ERROR (cycle 1 HREADYOUT=0 HRESP=1; cycle 2 HREADYOUT=1 HRESP=1), no memory write, HRDATA unchanged.
REQ-028 Macro AHB_ERR_RESP_EN undefined: illegal transfer SHALL complete zero-wait OKAY, write dropped, read returns HRDATA=0.
REQ-029 Address phase presented during ERROR cycle 1 SHALL be ignored (HREADY=0); slave returns to idle after cycle 2.

Verification
REQ-030 Reset, then word read of 0x10 -> HRDATA=0x00000000, HRESP=0, HREADYOUT=1.
REQ-031 Word write 0xDEADBEEF to 0x04, then word read 0x04 back-to-back -> HRDATA=0xDEADBEEF, zero wait.
REQ-032 Word 0x11223344 at 0x08, then byte write 0xAA at 0x09, halfword write 0x5566 at 0x0A -> read 0x08 = 0x5566AA44.
REQ-033 HTRANS=BUSY/IDLE and HSEL=0 with HWRITE=1 to 0x20 -> memory word 0x20 unchanged, HREADYOUT=1, HRESP=0.
REQ-034 With AHB_ERR_RESP_EN, word write to 0x02 -> HREADYOUT 0 then 1, HRESP 1 for both cycles, word 0x00 unchanged; without it -> OKAY, no write.
REQ-035 Write 0x12345678 at 0x3C, assert HRESETn one cycle -> read 0x3C returns 0x00000000.

Source files
------------

// File: rtl/modport_slave.sv
// Zero-wait 256-byte AHB-style memory slave with byte/halfword/word lane writes.
// Optional two-cycle ERROR response for illegal transfers: define AHB_ERR_RESP_EN.
module modport_slave (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [7:0]  HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

`ifdef AHB_ERR_RESP_EN
    localparam bit ERR_RESP_EN = 1'b1;
`else
    localparam bit ERR_RESP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] mem [64];
    logic        wr_pend;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_size;
    logic [3:0]  wr_mask;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic        legal;
    logic        accept;
    logic        unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT};

    // ERROR cycle 1 drives HREADYOUT low, so any address phase seen then is ignored
    assign accept = HSEL & HREADY & HTRANS[1] & (state != ST_ERR1);

    always_comb begin
        legal = 1'b0;
        case (HSIZE)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~HADDR[0];
            3'd2:    legal = (HADDR[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        wr_mask = 4'b1111;
        case (wr_size)
            2'd0:    wr_mask = 4'b0001 << wr_addr[1:0];
            2'd1:    wr_mask = wr_addr[1] ? 4'b1100 : 4'b0011;
            default: wr_mask = 4'b1111;
        endcase
    end

    // Merged write word doubles as the forwarding path for a read issued back-to-back
    always_comb begin
        wr_word = mem[wr_addr[7:2]];
        for (int unsigned n = 0; n < 4; n++) begin
            if (wr_mask[n]) wr_word[8*n +: 8] = HWDATA[8*n +: 8];
        end
        if (wr_pend && (wr_addr[7:2] == HADDR[7:2])) rd_word = wr_word;
        else                                         rd_word = mem[HADDR[7:2]];
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            for (int unsigned i = 0; i < 64; i++) mem[i] <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_size <= '0;
            HRDATA  <= '0;
        end else begin
            if (wr_pend) mem[wr_addr[7:2]] <= wr_word;
            wr_pend <= accept & HWRITE & legal;
            if (accept) begin
                wr_addr <= HADDR;
                wr_size <= HSIZE[1:0];
            end
            if (accept && !HWRITE) begin
                if (legal)             HRDATA <= rd_word;
                else if (!ERR_RESP_EN) HRDATA <= '0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ERR_RESP_EN && accept && !legal) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
                if (ERR_RESP_EN && accept && !legal) state_nxt = ST_ERR1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_modport_slave.sv
// Self-checking bench for modport_slave: directed scenarios then random traffic
// against a byte-array reference model.
module tb_modport_slave;

`ifdef AHB_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    always #5 HCLK = ~HCLK;

    modport_slave dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    // Reference model state
    logic [7:0]  mb [256];
    logic [31:0] exp_rdata;
    bit          m_pend;
    int          m_paddr;
    int          m_pbytes;
    int          m_err;       // 0 none, 1 first ERROR cycle, 2 second ERROR cycle
    int          vectors;
    int          miscompares;

    function automatic bit is_legal(input int size, input int addr);
        return (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && addr % 4 == 0);
    endfunction

    function automatic logic [31:0] word_at(input int addr);
        int base;
        base = addr - addr % 4;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic sel, input logic [1:0] trans,
                        input logic ready, input logic write, input logic [2:0] size,
                        input logic [7:0] addr, input logic [31:0] wdata);
        bit in_err1;
        HRESETn = rst; HSEL = sel; HTRANS = trans; HREADY = ready; HWRITE = write;
        HSIZE = size; HADDR = addr; HWDATA = wdata;
        HBURST = 3'($urandom_range(0, 7)); HPROT = 4'($urandom_range(0, 15));
        @(posedge HCLK);
        if (rst) begin
            for (int i = 0; i < 256; i++) mb[i] = 8'h00;
            exp_rdata = 32'h0;
            m_pend = 1'b0;
            m_err = 0;
        end else begin
            in_err1 = (m_err == 1);
            if (m_pend) begin
                for (int b = 0; b < m_pbytes; b++)
                    mb[m_paddr + b] = wdata[8*(m_paddr % 4 + b) +: 8];
            end
            m_pend = 1'b0;
            m_err = in_err1 ? 2 : 0;
            if (sel && ready && trans[1] && !in_err1) begin
                if (is_legal(int'(size), int'(addr))) begin
                    if (write) begin
                        m_pend = 1'b1;
                        m_paddr = int'(addr);
                        m_pbytes = 1 << size;
                    end else begin
                        exp_rdata = word_at(int'(addr));
                    end
                end else if (ERR_EN) begin
                    m_err = 1;
                end else if (!write) begin
                    exp_rdata = 32'h0;
                end
            end
        end
        #1;
        chk("hrdata", HRDATA, exp_rdata);
        chk("hreadyout", 32'(HREADYOUT), 32'(m_err != 1));
        chk("hresp", 32'(HRESP), 32'(m_err != 0));
    endtask

    initial begin
        logic [2:0] sz;
        logic [7:0] ad;
        vectors = 0;
        miscompares = 0;
        m_pend = 1'b0;
        m_err = 0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;

        // Reset
        tick(1, 0, 2'd0, 1, 0, 3'd0, 8'h00, 32'h0);
        tick(1, 1, 2'd2, 1, 1, 3'd2, 8'h10, 32'h0);
        chk("reset_hrdata", HRDATA, 32'h0);
        chk("reset_ready", 32'(HREADYOUT), 32'd1);

        // Read after reset
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h10, 32'h0);
        chk("rd_after_reset", HRDATA, 32'h0);

        // Back-to-back write/read
        tick(0, 1, 2'd2, 1, 1, 3'd2, 8'h04, 32'h0);
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h04, 32'hDEADBEEF);
        chk("b2b_rd", HRDATA, 32'hDEADBEEF);
        chk("b2b_ready", 32'(HREADYOUT), 32'd1);

        // Byte and halfword lanes
        tick(0, 1, 2'd2, 1, 1, 3'd2, 8'h08, 32'h0);
        tick(0, 1, 2'd3, 1, 1, 3'd0, 8'h09, 32'h11223344);
        tick(0, 1, 2'd3, 1, 1, 3'd1, 8'h0A, 32'h0000AA00);
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h08, 32'h55660000);
        chk("lanes_rd", HRDATA, 32'h5566AA44);

        // No-transfer cases leave memory untouched
        tick(0, 1, 2'd2, 1, 1, 3'd2, 8'h20, 32'h0);
        tick(0, 0, 2'd0, 1, 0, 3'd0, 8'h00, 32'hCAFEF00D);
        tick(0, 1, 2'd1, 1, 1, 3'd2, 8'h20, 32'hFFFFFFFF);
        tick(0, 1, 2'd0, 1, 1, 3'd2, 8'h20, 32'hFFFFFFFF);
        tick(0, 0, 2'd2, 1, 1, 3'd2, 8'h20, 32'hFFFFFFFF);
        tick(0, 1, 2'd2, 0, 1, 3'd2, 8'h20, 32'hFFFFFFFF);
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h20, 32'hFFFFFFFF);
        chk("notrans_rd", HRDATA, 32'hCAFEF00D);

        // Misaligned word write
        tick(0, 1, 2'd2, 1, 1, 3'd2, 8'h02, 32'h0);
        chk("illegal_c1_ready", 32'(HREADYOUT), ERR_EN ? 32'd0 : 32'd1);
        chk("illegal_c1_resp", 32'(HRESP), ERR_EN ? 32'd1 : 32'd0);
        tick(0, 1, 2'd2, 0, 1, 3'd2, 8'h00, 32'h99999999);
        chk("illegal_c2_ready", 32'(HREADYOUT), 32'd1);
        chk("illegal_c2_resp", 32'(HRESP), ERR_EN ? 32'd1 : 32'd0);
        tick(0, 0, 2'd0, 1, 0, 3'd0, 8'h00, 32'h99999999);
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h00, 32'h0);
        chk("illegal_nowrite", HRDATA, 32'h0);

        // Reset aborts an ERROR response
        tick(0, 1, 2'd2, 1, 0, 3'd1, 8'h05, 32'h0);
        tick(1, 0, 2'd0, 1, 0, 3'd0, 8'h00, 32'h0);
        chk("rst_abort_ready", 32'(HREADYOUT), 32'd1);
        chk("rst_abort_resp", 32'(HRESP), 32'd0);

        // Reset clears memory and discards a coinciding transfer
        tick(0, 1, 2'd2, 1, 1, 3'd2, 8'h3C, 32'h0);
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h3C, 32'h12345678);
        chk("pre_rst_rd", HRDATA, 32'h12345678);
        tick(1, 1, 2'd2, 1, 1, 3'd2, 8'h3C, 32'h0);
        tick(0, 1, 2'd2, 1, 0, 3'd2, 8'h3C, 32'hFFFFFFFF);
        chk("post_rst_rd", HRDATA, 32'h0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            ad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)), sz, ad, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
